// File: rtl/upc_cart_player.sv
// rtl/upc_cart_player.sv - cart FIFO that plays UPC/Mark items with fixed dwell and gap; option macro CART_LOOP_EN
module upc_cart_player #(
   parameter int DEPTH = 4,
   parameter int DWELL = 4,
   parameter int GAP   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic [2:0]                 load_upc,
   input  logic                       load_mark,
   input  logic                       play,
   output logic [2:0]                 upc,
   output logic                       mark,
   output logic                       item_valid,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int TMAX = (DWELL > GAP) ? DWELL : GAP;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHOW = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [1:0]    state;
   logic [1:0]    state_n;
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_n;
   logic          pop;
   logic          push;
   logic [3:0]    push_data;
   logic [CW-1:0] count_n;

   // Playback sequencing: decides when to pop the head and where the dwell/gap timer goes next.
   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      pop     = 1'b0;
      case (state)
         S_IDLE: begin
            if (play && !empty) begin
               pop     = 1'b1;
               state_n = S_SHOW;
               tmr_n   = '0;
            end
         end
         S_SHOW: begin
            if (play) begin
               state_n = S_IDLE;
               tmr_n   = '0;
            end else if (tmr == TW'(DWELL - 1)) begin
               state_n = S_GAP;
               tmr_n   = '0;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         S_GAP: begin
            if (play) begin
               state_n = S_IDLE;
               tmr_n   = '0;
            end else if (tmr == TW'(GAP - 1)) begin
               tmr_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = S_SHOW;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            tmr_n   = '0;
         end
      endcase
   end

   // Tail write source: in loop mode the popped item is recycled and overrides any external load.
   always_comb begin
`ifdef CART_LOOP_EN
      push      = pop | (load & ~full);
      push_data = pop ? mem[rd_ptr] : {load_upc, load_mark};
`else
      push      = load & ~full;
      push_data = {load_upc, load_mark};
`endif
   end

   // Occupancy after this cycle's push/pop; both together leave it unchanged.
   always_comb begin
      count_n = count;
      if (push && !pop)
         count_n = count + 1'b1;
      else if (pop && !push)
         count_n = count - 1'b1;
   end

   // Cart storage; entries need no reset because the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!reset && push)
         mem[wr_ptr] <= push_data;
   end

   // Registered control, pointers, occupancy flags and presented item.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         tmr        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         busy       <= 1'b0;
         upc        <= 3'b000;
         mark       <= 1'b0;
         item_valid <= 1'b0;
      end else begin
         state <= state_n;
         tmr   <= tmr_n;
         busy  <= (state_n != S_IDLE);
         count <= count_n;
         full  <= (count_n == CW'(DEPTH));
         empty <= (count_n == '0);
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            upc        <= mem[rd_ptr][3:1];
            mark       <= mem[rd_ptr][0];
            item_valid <= 1'b1;
         end else if (state_n != S_SHOW) begin
            upc        <= 3'b000;
            mark       <= 1'b0;
            item_valid <= 1'b0;
         end
      end
   end

endmodule
